// File: rtl/hilo_mdu_ctrl_if.sv
// E-stage multiply/divide request bus and HI/LO readback.
// The master is the pipeline side; the slave is hilo_mdu_ctrl.
interface hilo_mdu_ctrl_if;
    logic        start;
    logic [1:0]  md_op;
    logic        mt_we;
    logic        mt_sel;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_op, mt_we, mt_sel, rs_data, rt_data,
        input  busy, hi, lo
    );

    modport slave (
        input  start, md_op, mt_we, mt_sel, rs_data, rt_data,
        output busy, hi, lo
    );
endinterface

// File: rtl/hilo_mdu_ctrl.sv
// Multiply/divide sequencer owning the HI/LO pair: latches operands on start,
// holds busy for a fixed cycle count, then commits the result to HI/LO.
module hilo_mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic            clk,
    input logic            reset,
    hilo_mdu_ctrl_if.slave md
);

    typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

    localparam logic [3:0] MulLoad = 4'(MULT_CYCLES);
    localparam logic [3:0] DivLoad = 4'(DIV_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [63:0] prod_s, prod_u;
    logic        is_signed_div, a_neg, b_neg;
    logic [31:0] mag_a, mag_b, div_den, quo_u, rem_u, quo, rem;

    always_comb begin
        prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        prod_u = {32'b0, a_q} * {32'b0, b_q};
    end

    // Signed divide via magnitudes so truncation and remainder sign are explicit;
    // 0x80000000 / -1 falls out as 0x80000000 with no special case.
    always_comb begin
        is_signed_div = ~op_q[0];
        a_neg         = is_signed_div & a_q[31];
        b_neg         = is_signed_div & b_q[31];
        mag_a         = a_neg ? (~a_q + 32'd1) : a_q;
        mag_b         = b_neg ? (~b_q + 32'd1) : b_q;
        div_den       = (mag_b == 32'd0) ? 32'd1 : mag_b;
        quo_u         = mag_a / div_den;
        rem_u         = mag_a % div_den;
        quo           = (a_neg ^ b_neg) ? (~quo_u + 32'd1) : quo_u;
        rem           = a_neg ? (~rem_u + 32'd1) : rem_u;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            StIdle: begin
                if (md.start) begin
                    a_d  = md.rs_data;
                    b_d  = md.rt_data;
                    op_d = md.md_op;
                    if (md.md_op[1]) begin
                        state_d = StDiv;
                        cnt_d   = DivLoad;
                    end else begin
                        state_d = StMul;
                        cnt_d   = MulLoad;
                    end
                end else if (md.mt_we) begin
                    if (md.mt_sel) begin
                        hi_d = md.rs_data;
                    end else begin
                        lo_d = md.rs_data;
                    end
                end
            end
            StMul, StDiv: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StIdle;
                    if (state_q == StMul) begin
                        {hi_d, lo_d} = op_q[0] ? prod_u : prod_s;
                    end else if (b_q != 32'd0) begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            op_q    <= 2'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign md.busy = md.start | (state_q != StIdle);
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Bench for hilo_mdu_ctrl: directed plan cases plus random ops checked
// against a 64-bit arithmetic reference model.
module tb_hilo_mdu_ctrl;

    localparam int unsigned MultCycles = 5;
    localparam int unsigned DivCycles  = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;

    hilo_mdu_ctrl_if md_bus ();

    hilo_mdu_ctrl #(
        .MULT_CYCLES (MultCycles),
        .DIV_CYCLES  (DivCycles)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md_bus.slave)
    );

    always #5 clk = ~clk;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural definitions.
    task automatic model_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, sq, sr;
        logic [63:0] p;
        case (op)
            2'd0: begin
                p = longint'($signed(a)) * longint'($signed(b));
                exp_hi = p[63:32];
                exp_lo = p[31:0];
            end
            2'd1: begin
                p = 64'(a) * 64'(b);
                exp_hi = p[63:32];
                exp_lo = p[31:0];
            end
            2'd2: if (b != 0) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                sq = sa / sb;
                sr = sa % sb;
                exp_lo = sq[31:0];
                exp_hi = sr[31:0];
            end
            default: if (b != 0) begin
                exp_lo = a / b;
                exp_hi = a % b;
            end
        endcase
    endtask

    task automatic run_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit inject);
        int unsigned n;
        logic [31:0] old_hi, old_lo;
        n = op[1] ? DivCycles : MultCycles;
        old_hi = exp_hi;
        old_lo = exp_lo;
        @(negedge clk);
        md_bus.start = 1'b1;
        md_bus.md_op = op;
        md_bus.rs_data = a;
        md_bus.rt_data = b;
        #1;
        chk("busy_start", {31'b0, md_bus.busy}, 32'd1);
        for (int i = 1; i <= int'(n); i++) begin
            @(negedge clk);
            md_bus.start = 1'b0;
            md_bus.mt_we = 1'b0;
            if (inject && i == 2) begin
                md_bus.start = 1'b1;
                md_bus.md_op = 2'd3;
                md_bus.rs_data = 32'd9;
                md_bus.rt_data = 32'd2;
            end
            if (inject && i == 3) begin
                md_bus.mt_we = 1'b1;
                md_bus.mt_sel = 1'b1;
                md_bus.rs_data = 32'hAA;
            end
            #1;
            chk("busy_window", {31'b0, md_bus.busy}, 32'd1);
            chk("hi_hold", md_bus.hi, old_hi);
            chk("lo_hold", md_bus.lo, old_lo);
        end
        model_md(op, a, b);
        @(negedge clk);
        md_bus.start = 1'b0;
        md_bus.mt_we = 1'b0;
        #1;
        chk("busy_done", {31'b0, md_bus.busy}, 32'd0);
        chk("hi_result", md_bus.hi, exp_hi);
        chk("lo_result", md_bus.lo, exp_lo);
    endtask

    task automatic run_mt(input logic sel, input logic [31:0] d);
        @(negedge clk);
        md_bus.mt_we = 1'b1;
        md_bus.mt_sel = sel;
        md_bus.rs_data = d;
        #1;
        chk("mt_busy", {31'b0, md_bus.busy}, 32'd0);
        if (sel) exp_hi = d;
        else exp_lo = d;
        @(negedge clk);
        md_bus.mt_we = 1'b0;
        #1;
        chk("mt_hi", md_bus.hi, exp_hi);
        chk("mt_lo", md_bus.lo, exp_lo);
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b;
        md_bus.start = 1'b0;
        md_bus.md_op = 2'd0;
        md_bus.mt_we = 1'b0;
        md_bus.mt_sel = 1'b0;
        md_bus.rs_data = 32'd0;
        md_bus.rt_data = 32'd0;
        #1;
        chk("rst_busy", {31'b0, md_bus.busy}, 32'd0);
        chk("rst_hi", md_bus.hi, 32'd0);
        chk("rst_lo", md_bus.lo, 32'd0);
        #11 reset = 1'b0;

        run_md(2'd0, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
        chk("mult_neg_hi", md_bus.hi, 32'hFFFF_FFFF);
        chk("mult_neg_lo", md_bus.lo, 32'hFFFF_FFFA);
        run_md(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("multu_hi", md_bus.hi, 32'hFFFF_FFFE);
        chk("multu_lo", md_bus.lo, 32'h0000_0001);
        run_md(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        chk("div_neg_lo", md_bus.lo, 32'hFFFF_FFFD);
        chk("div_neg_hi", md_bus.hi, 32'hFFFF_FFFF);
        run_mt(1'b0, 32'h1234);
        run_mt(1'b1, 32'h5678);
        run_md(2'd3, 32'd5, 32'd0, 1'b0);
        chk("divz_hi", md_bus.hi, 32'h5678);
        chk("divz_lo", md_bus.lo, 32'h1234);
        run_md(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("divovf_lo", md_bus.lo, 32'h8000_0000);
        chk("divovf_hi", md_bus.hi, 32'h0000_0000);
        run_md(2'd0, 32'd3, 32'd4, 1'b1);
        chk("ignored_hi", md_bus.hi, 32'd0);
        chk("ignored_lo", md_bus.lo, 32'd12);

        // Reset in the fourth busy cycle of a divide, away from any edge.
        run_mt(1'b1, 32'hDEAD_BEEF);
        @(negedge clk);
        md_bus.start = 1'b1;
        md_bus.md_op = 2'd2;
        md_bus.rs_data = 32'd100;
        md_bus.rt_data = 32'd7;
        @(negedge clk);
        md_bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_busy", {31'b0, md_bus.busy}, 32'd0);
        chk("midrst_hi", md_bus.hi, 32'd0);
        chk("midrst_lo", md_bus.lo, 32'd0);
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        @(negedge clk);
        #3 reset = 1'b0;
        for (int i = 0; i < int'(DivCycles) + 3; i++) begin
            @(negedge clk);
            #1;
            chk("postrst_busy", {31'b0, md_bus.busy}, 32'd0);
            chk("postrst_hi", md_bus.hi, 32'd0);
            chk("postrst_lo", md_bus.lo, 32'd0);
        end

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 4) == 4) begin
                run_mt(1'($urandom_range(0, 1)), $urandom);
            end else begin
                op = 2'($urandom_range(0, 3));
                a = $urandom;
                case ($urandom_range(0, 5))
                    0: b = 32'd0;
                    1: b = 32'($urandom_range(1, 20));
                    2: b = 32'hFFFF_FFFF;
                    default: b = $urandom;
                endcase
                if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
                run_md(op, a, b, 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hilo_mdu_ctrl.md
Name: hilo_mdu_ctrl

Overview:
- Sequencer for the multiply/divide resource and the HI/LO register pair in the E stage of the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo from E and computes the result over a fixed number of cycles.
- Commits results to HI/LO and drives the busy flag that the stall unit consumes as HILO_busy.
- The stall unit holds any md/mf/mt instruction in D while this block reports busy.

Parameters:
- MULT_CYCLES, 5, busy cycles after start for mult/multu (range 1..15).
- DIV_CYCLES, 10, busy cycles after start for div/divu (range 1..15).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  E-stage md instruction valid this cycle (one-cycle pulse).
- md_op  input  2  operation: 00 mult, 01 multu, 10 div, 11 divu; sampled when start=1.
- mt_we  input  1  E-stage mthi/mtlo valid this cycle.
- mt_sel  input  1  0 = mtlo, 1 = mthi.
- rs_data  input  32  forwarded rs operand (dividend, multiplicand, or mt data).
- rt_data  input  32  forwarded rt operand (divisor or multiplier).
- busy  output  1  start | (state != IDLE); feeds HILO_busy.
- hi  output  32  architectural HI; read by mfhi.
- lo  output  32  architectural LO; read by mflo.

Behaviour:
- Reset (asynchronous, any time including mid-operation):
  - hi=0, lo=0, state=IDLE, counter=0, operand and result registers cleared.
  - busy=0 once start is low.
  - The in-flight operation is discarded and never committed.
- States: IDLE, MUL, DIV.
- IDLE with start=1:
  - Latch rs_data, rt_data and md_op at the clock edge.
  - Compute the 64-bit product or quotient/remainder into internal result registers (combinational from latched operands, or iterative; either is allowed if timing matches).
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to MUL or DIV.
- MUL/DIV:
  - Counter decrements each cycle.
  - On the edge where counter goes 1→0, commit the result to hi/lo and return to IDLE.
  - hi/lo hold their old values until that commit edge.
- Latency:
  - start at edge 0 → busy high from start's cycle through MULT_CYCLES further cycles.
  - New hi/lo are visible in the cycle after the last busy cycle.
  - The total busy window is MULT_CYCLES+1 cycles, including the start cycle. The same rule applies for div with DIV_CYCLES.
- mult: {hi,lo} = signed rs × signed rt. multu: unsigned 32×32→64.
- div / divu:
  - lo = quotient, hi = remainder.
  - Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
  - div 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0 (wraps, no trap).
- Divisor = 0: the operation still occupies DIV_CYCLES busy cycles; hi/lo are left unchanged at commit.
- mt_we=1 in IDLE with start=0: write rs_data to hi (mt_sel=1) or lo (mt_sel=0) at the next edge; busy stays 0.
- Simultaneous start and mt_we: start takes priority and mt_we is ignored. The stall unit prevents this case; it is defined only for robustness.
- start or mt_we while state != IDLE: ignored, with no effect on the operation or on hi/lo. The stall unit prevents this case.
- Pipeline-level behaviour, not enforced by this block: a D-stage mfhi/mflo is stalled while busy=1, so it never reads stale hi/lo.

Test Plan:
- mult, rs=0xFFFFFFFE (−2), rt=0x00000003:
  - busy high 6 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - hi/lo unchanged during the busy window.
- multu, rs=0xFFFFFFFF, rt=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001 after 6 busy cycles.
- div, rs=0xFFFFFFF9 (−7), rt=0x00000002:
  - busy high 11 cycles.
  - Then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Divide by zero and overflow:
  - mtlo 0x1234 then mthi 0x5678, then divu rs=5, rt=0 → hi=0x5678, lo=0x1234 after 11 busy cycles.
  - div 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Reset mid-operation:
  - Start div, assert reset asynchronously in busy cycle 4 (off the clock edge).
  - Required: busy=0, hi=lo=0 immediately, and no later commit after reset releases.
- Ignored requests while busy:
  - Start mult 3×4, then pulse start (divu 9/2) and mt_we (mthi 0xAA) during busy.
  - Required: final hi=0, lo=12, state IDLE after exactly 6 busy cycles.
